// File: rtl/rv_ctl.sv
`default_nettype none
// ============================================================================
// Module   : rv_ctl
// Purpose  : Multicycle control FSM for the RV32I datapath (rv_dp). Decodes
//            the IR contents and sequences every datapath enable and select,
//            one state per cycle. Supports R-type ALU, I-type ALU, LW, SW,
//            the six branches, JAL and JALR; any other opcode halts the core
//            until reset. Instruction and data memory accesses stall on the
//            imem_ready / dmem_ready handshakes.
// Ports    : clk, rst_n (async, active low)
//            instr      - IR contents from datapath
//            zero       - ALU result == 0 (combinational, current cycle)
//            imem_ready - instruction word valid this cycle
//            dmem_ready - data access completes this cycle
//            pcsourse, pcwrite, pccen, irwrite, wbsel, regwen, immsel,
//            asel, bsel, alusel, mdrwrite, dmem_ren, dmem_wen - datapath
//            controls; all combinational from state and instr
//            halted     - core stopped on an illegal instruction
// Options  : `define RV_CTL_PERF_CNT_EN adds cycle_cnt / instret_cnt
//            performance counter outputs (CNTWIDTH bits each).
// Revision : 1.0 - initial release
// ============================================================================
module rv_ctl #(
    parameter int DPWIDTH  = 32,
    parameter int CNTWIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DPWIDTH-1:0] instr,
    input  logic               zero,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    output logic               pcsourse,
    output logic               pcwrite,
    output logic               pccen,
    output logic               irwrite,
    output logic [1:0]         wbsel,
    output logic               regwen,
    output logic [1:0]         immsel,
    output logic [1:0]         asel,
    output logic [1:0]         bsel,
    output logic [3:0]         alusel,
    output logic               mdrwrite,
    output logic               dmem_ren,
    output logic               dmem_wen,
    output logic               halted
`ifdef RV_CTL_PERF_CNT_EN
    ,
    output logic [CNTWIDTH-1:0] cycle_cnt,
    output logic [CNTWIDTH-1:0] instret_cnt
`endif
);

    // ------------------------------------------------------------------------
    // Shared datapath select encodings (must match rv_dp)
    // ------------------------------------------------------------------------
    localparam logic       PC_PLUS4    = 1'b0;
    localparam logic       PC_ALU      = 1'b1;

    localparam logic [1:0] WB_MDR      = 2'd0;
    localparam logic [1:0] WB_ALUOUT   = 2'd1;
    localparam logic [1:0] WB_PC       = 2'd2;

    localparam logic [1:0] IMM_J       = 2'd0;
    localparam logic [1:0] IMM_B       = 2'd1;
    localparam logic [1:0] IMM_S       = 2'd2;
    localparam logic [1:0] IMM_L       = 2'd3;

    localparam logic [1:0] ALUA_REG    = 2'd0;
    localparam logic [1:0] ALUA_PCC    = 2'd1;
    localparam logic [1:0] ALUA_ALUOUT = 2'd2;

    localparam logic [1:0] ALUB_REG    = 2'd0;
    localparam logic [1:0] ALUB_IMM    = 2'd1;
    localparam logic [1:0] ALUB_F      = 2'd2;

    localparam logic [3:0] ALU_ADD     = 4'd0;
    localparam logic [3:0] ALU_SUB     = 4'd1;
    localparam logic [3:0] ALU_SLL     = 4'd2;
    localparam logic [3:0] ALU_SLT     = 4'd3;
    localparam logic [3:0] ALU_SLTU    = 4'd4;
    localparam logic [3:0] ALU_XOR     = 4'd5;
    localparam logic [3:0] ALU_SRL     = 4'd6;
    localparam logic [3:0] ALU_SRA     = 4'd7;
    localparam logic [3:0] ALU_OR      = 4'd8;
    localparam logic [3:0] ALU_AND     = 4'd9;

    // Opcodes of the supported subset
    localparam logic [6:0] c_op_reg    = 7'b0110011;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXR    = 4'd2,
        S_EXI    = 4'd3,
        S_WBA    = 4'd4,
        S_MADR   = 4'd5,
        S_MRD    = 4'd6,
        S_WBM    = 4'd7,
        S_MWR    = 4'd8,
        S_BR     = 4'd9,
        S_JAL    = 4'd10,
        S_JALR0  = 4'd11,
        S_JALR1  = 4'd12,
        S_ILL    = 4'd13
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // ------------------------------------------------------------------------
    // Instruction field decode
    // ------------------------------------------------------------------------
    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_funct7_5;
    logic       w_is_load;
    logic [3:0] w_alu_r;
    logic [3:0] w_alu_i;
    logic [3:0] w_alu_br;
    logic       w_br_taken;
    logic       w_br_illegal;

    assign w_opcode   = instr[6:0];
    assign w_funct3   = instr[14:12];
    assign w_funct7_5 = instr[30];
    assign w_is_load  = (w_opcode == c_op_load);

    // Register, rd and rs fields are consumed by the datapath only.
    logic w_unused_bits;
    assign w_unused_bits = ^{instr[DPWIDTH-1:31], instr[29:15], instr[11:7]};

    // R-type ALU operation: funct7[5] picks SUB and SRA.
    always_comb begin
        w_alu_r = ALU_ADD;
        case (w_funct3)
            3'b000:  w_alu_r = w_funct7_5 ? ALU_SUB : ALU_ADD;
            3'b001:  w_alu_r = ALU_SLL;
            3'b010:  w_alu_r = ALU_SLT;
            3'b011:  w_alu_r = ALU_SLTU;
            3'b100:  w_alu_r = ALU_XOR;
            3'b101:  w_alu_r = w_funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  w_alu_r = ALU_OR;
            default: w_alu_r = ALU_AND;
        endcase
    end

    // I-type ALU operation: bit 30 belongs to the immediate except for the
    // shift-right encoding, so ADDI with a negative immediate stays ADD.
    always_comb begin
        w_alu_i = w_alu_r;
        if (w_funct3 == 3'b000) begin
            w_alu_i = ALU_ADD;
        end
    end

    // Branch compare: equality through SUB, ordering through SLT/SLTU whose
    // result is nonzero (zero=0) exactly when rs1 < rs2.
    always_comb begin
        w_alu_br     = ALU_SUB;
        w_br_taken   = 1'b0;
        w_br_illegal = 1'b0;
        case (w_funct3)
            3'b000: begin w_alu_br = ALU_SUB;  w_br_taken = zero;  end // BEQ
            3'b001: begin w_alu_br = ALU_SUB;  w_br_taken = !zero; end // BNE
            3'b100: begin w_alu_br = ALU_SLT;  w_br_taken = !zero; end // BLT
            3'b101: begin w_alu_br = ALU_SLT;  w_br_taken = zero;  end // BGE
            3'b110: begin w_alu_br = ALU_SLTU; w_br_taken = !zero; end // BLTU
            3'b111: begin w_alu_br = ALU_SLTU; w_br_taken = zero;  end // BGEU
            default: w_br_illegal = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        pcsourse     = PC_PLUS4;
        pcwrite      = 1'b0;
        pccen        = 1'b0;
        irwrite      = 1'b0;
        wbsel        = WB_ALUOUT;
        regwen       = 1'b0;
        immsel       = IMM_L;
        asel         = ALUA_REG;
        bsel         = ALUB_REG;
        alusel       = ALU_ADD;
        mdrwrite     = 1'b0;
        dmem_ren     = 1'b0;
        dmem_wen     = 1'b0;
        halted       = 1'b0;

        case (r_state)
            S_FETCH: begin
                if (imem_ready) begin
                    irwrite      = 1'b1;
                    pccen        = 1'b1;
                    pcwrite      = 1'b1;
                    pcsourse     = PC_PLUS4;
                    w_next_state = S_DECODE;
                end
            end

            S_DECODE: begin
                // pcc + imm lands in aluout as the branch / JAL target.
                asel   = ALUA_PCC;
                bsel   = ALUB_IMM;
                alusel = ALU_ADD;
                immsel = (w_opcode == c_op_jal) ? IMM_J : IMM_B;
                case (w_opcode)
                    c_op_reg:    w_next_state = S_EXR;
                    c_op_imm:    w_next_state = S_EXI;
                    c_op_load:   w_next_state = S_MADR;
                    c_op_store:  w_next_state = S_MADR;
                    c_op_branch: w_next_state = S_BR;
                    c_op_jal:    w_next_state = S_JAL;
                    c_op_jalr:   w_next_state = S_JALR0;
                    default:     w_next_state = S_ILL;
                endcase
            end

            S_EXR: begin
                alusel       = w_alu_r;
                w_next_state = S_WBA;
            end

            S_EXI: begin
                bsel         = ALUB_IMM;
                immsel       = IMM_L;
                alusel       = w_alu_i;
                w_next_state = S_WBA;
            end

            S_WBA: begin
                wbsel        = WB_ALUOUT;
                regwen       = 1'b1;
                w_next_state = S_FETCH;
            end

            S_MADR: begin
                bsel         = ALUB_IMM;
                alusel       = ALU_ADD;
                immsel       = w_is_load ? IMM_L : IMM_S;
                w_next_state = w_is_load ? S_MRD : S_MWR;
            end

            S_MRD: begin
                dmem_ren = 1'b1;
                if (dmem_ready) begin
                    mdrwrite     = 1'b1;
                    w_next_state = S_WBM;
                end
            end

            S_WBM: begin
                wbsel        = WB_MDR;
                regwen       = 1'b1;
                w_next_state = S_FETCH;
            end

            S_MWR: begin
                // Keep recomputing the store address so aluout does not move
                // while the write waits for dmem_ready.
                dmem_wen = 1'b1;
                bsel     = ALUB_IMM;
                alusel   = ALU_ADD;
                immsel   = IMM_S;
                if (dmem_ready) begin
                    w_next_state = S_FETCH;
                end
            end

            S_BR: begin
                alusel = w_alu_br;
                if (w_br_illegal) begin
                    w_next_state = S_ILL;
                end else begin
                    if (w_br_taken) begin
                        pcwrite  = 1'b1;
                        pcsourse = PC_ALU;
                    end
                    w_next_state = S_FETCH;
                end
            end

            S_JAL: begin
                // pc already holds the link address from FETCH.
                regwen       = 1'b1;
                wbsel        = WB_PC;
                pcwrite      = 1'b1;
                pcsourse     = PC_ALU;
                w_next_state = S_FETCH;
            end

            S_JALR0: begin
                bsel         = ALUB_IMM;
                immsel       = IMM_L;
                alusel       = ALU_ADD;
                w_next_state = S_JALR1;
            end

            S_JALR1: begin
                // Target bit 0 is left as computed; the datapath only
                // supports word-aligned fetch.
                regwen       = 1'b1;
                wbsel        = WB_PC;
                pcwrite      = 1'b1;
                pcsourse     = PC_ALU;
                w_next_state = S_FETCH;
            end

            S_ILL: begin
                halted       = 1'b1;
                w_next_state = S_ILL;
            end

            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Optional performance counters
    // ------------------------------------------------------------------------
`ifdef RV_CTL_PERF_CNT_EN
    logic [CNTWIDTH-1:0] r_cycle_cnt;
    logic [CNTWIDTH-1:0] r_instret_cnt;
    logic                w_retire;

    // An instruction retires whenever the FSM re-enters FETCH.
    assign w_retire = (r_state != S_FETCH) && (w_next_state == S_FETCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else if (r_state != S_ILL) begin
            r_cycle_cnt <= r_cycle_cnt + 1'b1;
            if (w_retire) begin
                r_instret_cnt <= r_instret_cnt + 1'b1;
            end
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;
`else
    localparam int c_unused_cntwidth = CNTWIDTH;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rv_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_ctl
// Purpose  : Self-checking testbench for rv_ctl. A table of per-cycle
//            {inputs, expected controls} records walks the FSM through every
//            instruction class, followed by hand-written sequences for
//            asynchronous reset, illegal-instruction halt and the optional
//            performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_ctl;

    localparam logic       PC_PLUS4  = 1'b0;
    localparam logic       PC_ALU    = 1'b1;
    localparam logic [1:0] WB_MDR    = 2'd0;
    localparam logic [1:0] WB_ALUOUT = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;
    localparam logic [1:0] IMM_J     = 2'd0;
    localparam logic [1:0] IMM_B     = 2'd1;
    localparam logic [1:0] IMM_S     = 2'd2;
    localparam logic [1:0] IMM_L     = 2'd3;
    localparam logic [1:0] ALUA_REG  = 2'd0;
    localparam logic [1:0] ALUA_PCC  = 2'd1;
    localparam logic [1:0] ALUB_REG  = 2'd0;
    localparam logic [1:0] ALUB_IMM  = 2'd1;
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_SRA   = 4'd7;

    // Hand-assembled instructions
    localparam logic [31:0] I_ADD   = 32'h002081B3; // add  x3,x1,x2
    localparam logic [31:0] I_SUB   = 32'h402081B3; // sub  x3,x1,x2
    localparam logic [31:0] I_SLTU  = 32'h0020B1B3; // sltu x3,x1,x2
    localparam logic [31:0] I_ADDIN = 32'hC0000093; // addi x1,x0,-1024
    localparam logic [31:0] I_SRAI  = 32'h4030D093; // srai x1,x1,3
    localparam logic [31:0] I_LW    = 32'h0080A283; // lw   x5,8(x1)
    localparam logic [31:0] I_SW    = 32'h0020A623; // sw   x2,12(x1)
    localparam logic [31:0] I_BNE   = 32'h00209063; // bne  x1,x2,0
    localparam logic [31:0] I_BLT   = 32'h0020C063; // blt  x1,x2,0
    localparam logic [31:0] I_BGE   = 32'h0020D063; // bge  x1,x2,0
    localparam logic [31:0] I_BLTU  = 32'h0020E063; // bltu x1,x2,0
    localparam logic [31:0] I_BR010 = 32'h0020A063; // branch, funct3=010
    localparam logic [31:0] I_JAL   = 32'h010000EF; // jal  x1,+16
    localparam logic [31:0] I_JALR  = 32'h000100E7; // jalr x1,0(x2)
    localparam logic [31:0] I_LUI   = 32'h000010B7; // lui  x1,1

    typedef struct packed {
        logic       pcsourse;
        logic       pcwrite;
        logic       pccen;
        logic       irwrite;
        logic [1:0] wbsel;
        logic       regwen;
        logic [1:0] immsel;
        logic [1:0] asel;
        logic [1:0] bsel;
        logic [3:0] alusel;
        logic       mdrwrite;
        logic       dmem_ren;
        logic       dmem_wen;
        logic       halted;
    } ctl_t;

    typedef struct {
        logic [31:0] instr;
        logic        zero;
        logic        imem_ready;
        logic        dmem_ready;
        ctl_t        exp;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = I_ADD;
    logic        zero = 1'b0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        pcsourse, pcwrite, pccen, irwrite, regwen;
    logic [1:0]  wbsel, immsel, asel, bsel;
    logic [3:0]  alusel;
    logic        mdrwrite, dmem_ren, dmem_wen, halted;
`ifdef RV_CTL_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    int n_pass  = 0;
    int n_total = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    rv_ctl #(.DPWIDTH(32), .CNTWIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .zero       (zero),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .pcsourse   (pcsourse),
        .pcwrite    (pcwrite),
        .pccen      (pccen),
        .irwrite    (irwrite),
        .wbsel      (wbsel),
        .regwen     (regwen),
        .immsel     (immsel),
        .asel       (asel),
        .bsel       (bsel),
        .alusel     (alusel),
        .mdrwrite   (mdrwrite),
        .dmem_ren   (dmem_ren),
        .dmem_wen   (dmem_wen),
        .halted     (halted)
`ifdef RV_CTL_PERF_CNT_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .instret_cnt(instret_cnt)
`endif
    );

    // Idle controls: every enable low, default selects.
    function automatic ctl_t D();
        ctl_t e;
        e = '0;
        e.pcsourse = PC_PLUS4;
        e.wbsel    = WB_ALUOUT;
        e.immsel   = IMM_L;
        e.asel     = ALUA_REG;
        e.bsel     = ALUB_REG;
        e.alusel   = ALU_ADD;
        return e;
    endfunction

    function automatic ctl_t F();
        ctl_t e;
        e = D();
        e.irwrite = 1'b1;
        e.pccen   = 1'b1;
        e.pcwrite = 1'b1;
        return e;
    endfunction

    function automatic ctl_t DEC(input logic is_jal);
        ctl_t e;
        e = D();
        e.asel   = ALUA_PCC;
        e.bsel   = ALUB_IMM;
        e.immsel = is_jal ? IMM_J : IMM_B;
        return e;
    endfunction

    function automatic ctl_t WBA();
        ctl_t e;
        e = D();
        e.regwen = 1'b1;
        e.wbsel  = WB_ALUOUT;
        return e;
    endfunction

    function automatic ctl_t ALUOP(input logic [1:0] b, input logic [1:0] imm,
                                   input logic [3:0] op);
        ctl_t e;
        e = D();
        e.bsel   = b;
        e.immsel = imm;
        e.alusel = op;
        return e;
    endfunction

    function automatic ctl_t BRX(input logic [3:0] op, input logic taken);
        ctl_t e;
        e = D();
        e.alusel = op;
        if (taken) begin
            e.pcwrite  = 1'b1;
            e.pcsourse = PC_ALU;
        end
        return e;
    endfunction

    function automatic ctl_t LINK();
        ctl_t e;
        e = D();
        e.regwen   = 1'b1;
        e.wbsel    = WB_PC;
        e.pcwrite  = 1'b1;
        e.pcsourse = PC_ALU;
        return e;
    endfunction

    task automatic av(input logic [31:0] ins, input logic z, input logic ir,
                      input logic dr, input ctl_t e, input string n);
        vec_t v;
        v.instr = ins; v.zero = z; v.imem_ready = ir; v.dmem_ready = dr;
        v.exp = e; v.name = n;
        vq.push_back(v);
    endtask

    task automatic chk(input string n, input ctl_t e);
        ctl_t act;
        act = {pcsourse, pcwrite, pccen, irwrite, wbsel, regwen, immsel,
               asel, bsel, alusel, mdrwrite, dmem_ren, dmem_wen, halted};
        n_total++;
        if (act === e) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", n, act, e);
        end
    endtask

    task automatic chk1(input string n, input logic act, input logic e);
        n_total++;
        if (act === e) n_pass++;
        else $display("FAIL %s: got %b expected %b", n, act, e);
    endtask

    // Drive one cycle's inputs at the falling edge, settle, then return.
    task automatic drive(input logic [31:0] ins, input logic z,
                         input logic ir, input logic dr);
        @(negedge clk);
        instr = ins; zero = z; imem_ready = ir; dmem_ready = dr;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        imem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        ctl_t e;

        // ---------------- reset state ----------------
        #3;
        chk("reset_idle", D());
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- vector table ----------------
        av(I_ADD, 0, 0, 1, D(), "fetch_stall");
        av(I_ADD, 0, 1, 1, F(), "add_fetch");
        av(I_ADD, 0, 1, 1, DEC(0), "add_decode");
        av(I_ADD, 0, 1, 1, ALUOP(ALUB_REG, IMM_L, ALU_ADD), "add_exr");
        av(I_ADD, 0, 1, 1, WBA(), "add_wba");

        av(I_SUB, 0, 1, 1, F(), "sub_fetch");
        av(I_SUB, 0, 1, 1, DEC(0), "sub_decode");
        av(I_SUB, 0, 1, 1, ALUOP(ALUB_REG, IMM_L, ALU_SUB), "sub_exr");
        av(I_SUB, 0, 1, 1, WBA(), "sub_wba");

        av(I_SLTU, 0, 1, 1, F(), "sltu_fetch");
        av(I_SLTU, 0, 1, 1, DEC(0), "sltu_decode");
        av(I_SLTU, 0, 1, 1, ALUOP(ALUB_REG, IMM_L, ALU_SLTU), "sltu_exr");
        av(I_SLTU, 0, 1, 1, WBA(), "sltu_wba");

        av(I_ADDIN, 0, 1, 1, F(), "addi_fetch");
        av(I_ADDIN, 0, 1, 1, DEC(0), "addi_decode");
        av(I_ADDIN, 0, 1, 1, ALUOP(ALUB_IMM, IMM_L, ALU_ADD), "addi_neg_exi");
        av(I_ADDIN, 0, 1, 1, WBA(), "addi_wba");

        av(I_SRAI, 0, 1, 1, F(), "srai_fetch");
        av(I_SRAI, 0, 1, 1, DEC(0), "srai_decode");
        av(I_SRAI, 0, 1, 1, ALUOP(ALUB_IMM, IMM_L, ALU_SRA), "srai_exi");
        av(I_SRAI, 0, 1, 1, WBA(), "srai_wba");

        // Load with three wait cycles before dmem_ready
        av(I_LW, 0, 1, 1, F(), "lw_fetch");
        av(I_LW, 0, 1, 1, DEC(0), "lw_decode");
        av(I_LW, 0, 1, 1, ALUOP(ALUB_IMM, IMM_L, ALU_ADD), "lw_madr");
        e = D(); e.dmem_ren = 1'b1;
        av(I_LW, 0, 1, 0, e, "lw_mrd_wait1");
        av(I_LW, 0, 1, 0, e, "lw_mrd_wait2");
        av(I_LW, 0, 1, 0, e, "lw_mrd_wait3");
        e.mdrwrite = 1'b1;
        av(I_LW, 0, 1, 1, e, "lw_mrd_ready");
        e = D(); e.regwen = 1'b1; e.wbsel = WB_MDR;
        av(I_LW, 0, 1, 1, e, "lw_wbm");

        // Store with one wait cycle
        av(I_SW, 0, 1, 1, F(), "sw_fetch");
        av(I_SW, 0, 1, 1, DEC(0), "sw_decode");
        av(I_SW, 0, 1, 1, ALUOP(ALUB_IMM, IMM_S, ALU_ADD), "sw_madr");
        e = ALUOP(ALUB_IMM, IMM_S, ALU_ADD); e.dmem_wen = 1'b1;
        av(I_SW, 0, 1, 0, e, "sw_mwr_wait");
        av(I_SW, 0, 1, 1, e, "sw_mwr_ready");

        av(I_BNE, 0, 1, 1, F(), "bne_t_fetch");
        av(I_BNE, 0, 1, 1, DEC(0), "bne_t_decode");
        av(I_BNE, 0, 1, 1, BRX(ALU_SUB, 1), "bne_taken");
        av(I_BNE, 0, 1, 1, F(), "bne_n_fetch");
        av(I_BNE, 0, 1, 1, DEC(0), "bne_n_decode");
        av(I_BNE, 1, 1, 1, BRX(ALU_SUB, 0), "bne_not_taken");

        av(I_BGE, 0, 1, 1, F(), "bge_fetch");
        av(I_BGE, 0, 1, 1, DEC(0), "bge_decode");
        av(I_BGE, 1, 1, 1, BRX(ALU_SLT, 1), "bge_taken");
        av(I_BLT, 0, 1, 1, F(), "blt_fetch");
        av(I_BLT, 0, 1, 1, DEC(0), "blt_decode");
        av(I_BLT, 1, 1, 1, BRX(ALU_SLT, 0), "blt_not_taken");
        av(I_BLTU, 0, 1, 1, F(), "bltu_fetch");
        av(I_BLTU, 0, 1, 1, DEC(0), "bltu_decode");
        av(I_BLTU, 0, 1, 1, BRX(ALU_SLTU, 1), "bltu_taken");

        av(I_JAL, 0, 1, 1, F(), "jal_fetch");
        av(I_JAL, 0, 1, 1, DEC(1), "jal_decode");
        av(I_JAL, 0, 1, 1, LINK(), "jal_link");

        av(I_JALR, 0, 1, 1, F(), "jalr_fetch");
        av(I_JALR, 0, 1, 1, DEC(0), "jalr_decode");
        av(I_JALR, 0, 1, 1, ALUOP(ALUB_IMM, IMM_L, ALU_ADD), "jalr0");
        av(I_JALR, 0, 1, 1, LINK(), "jalr1");
        av(I_ADD, 0, 0, 1, D(), "back_in_fetch");

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].instr, vq[i].zero, vq[i].imem_ready, vq[i].dmem_ready);
            chk(vq[i].name, vq[i].exp);
        end

        // ------- asynchronous reset while a load waits in MRD -------
        drive(I_LW, 0, 1, 0);
        drive(I_LW, 0, 1, 0);
        drive(I_LW, 0, 1, 0);
        drive(I_LW, 0, 1, 0);
        chk1("mrd_ren_before_reset", dmem_ren, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk1("mrd_ren_async_drop", dmem_ren, 1'b0);
        chk("async_reset_to_fetch", F());
        @(negedge clk);
        rst_n = 1'b1;

        // ------- branch with reserved funct3 halts the core -------
        drive(I_BR010, 0, 1, 1);
        drive(I_BR010, 0, 1, 1);
        drive(I_BR010, 0, 1, 1);
        drive(I_BR010, 0, 1, 1);
        e = D(); e.halted = 1'b1;
        chk("br_funct3_010_ill", e);

        // ------- LUI is unsupported: halt sticks for 100 cycles -------
        do_reset();
        #1;
        chk1("reset_clears_halt", halted, 1'b0);
        drive(I_LUI, 0, 1, 1);
        chk("lui_fetch", F());
        drive(I_LUI, 0, 1, 1);
        chk("lui_decode", DEC(0));
        for (int i = 0; i < 100; i++) begin
            drive(I_LUI, i[0], 1, 1);
            chk($sformatf("lui_ill_%0d", i), e);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_ill_reset_fetch", F());

`ifdef RV_CTL_PERF_CNT_EN
        // ------- 10 zero-wait ADDs: 40 cycles, 10 retired -------
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_total++;
        if (cycle_cnt === 32'd0 && instret_cnt === 32'd0) n_pass++;
        else $display("FAIL perf_reset: got %0d/%0d expected 0/0", cycle_cnt, instret_cnt);
        @(negedge clk);
        rst_n = 1'b1;
        instr = I_ADD; zero = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        n_total++;
        if (cycle_cnt === 32'd40) n_pass++;
        else $display("FAIL perf_cycle_cnt: got %0d expected 40", cycle_cnt);
        n_total++;
        if (instret_cnt === 32'd10) n_pass++;
        else $display("FAIL perf_instret_cnt: got %0d expected 10", instret_cnt);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
